if_id_pipe_elastic: RTL and testbench

- Parametrised fetch-to-decode pipeline register; replaces the free-running IF/ID latch with an elastic stage.
- Adds valid/ready handshake, stall back-pressure, synchronous flush on branch/jump redirect and an optional 2-entry skid buffer, so fetch can run at full rate without a combinational ready path.
- Sits between the PC/instruction-memory fetch logic and the decode stage.
- Also provides a saturating stall counter for performance debug.

---
 rtl/if_id_pipe_elastic.sv | 112 +++++++++++
 tb/tb_if_id_pipe_elastic.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_elastic.sv
// Elastic IF/ID register: valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall counter.
module if_id_pipe_elastic #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32,
  parameter int unsigned SKID = 1,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ent_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       st_q, st_d;
  ent_t             main_q, skid_q, in_e;
  logic             rdy_q;
  logic             acc, drn;
  logic             ld_in, ld_skid, ld_fwd;
  logic [CNT_W-1:0] cnt_q;

  assign in_e = '{pc: in_pc, instr: in_instr};

  // With SKID=0 the TWO state is unreachable: in ONE an
  // accept implies a drain because ready follows out_ready.
  assign in_ready = (SKID != 0) ? rdy_q
                  : (!rst && (!out_valid || out_ready));

  assign out_valid = (st_q != S_EMPTY);
  assign out_pc    = main_q.pc;
  assign out_instr = out_valid ? main_q.instr : NOP_INSTR;
  assign stall_cnt = cnt_q;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_comb begin
    st_d    = st_q;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    ld_fwd  = 1'b0;
    unique case (1'b1)
      st_q == S_ONE: begin
        if (acc && drn) begin
          ld_in = 1'b1;
        end else if (acc) begin
          ld_skid = 1'b1;
          st_d    = S_TWO;
        end else if (drn) begin
          st_d = S_EMPTY;
        end
      end
      st_q == S_TWO: begin
        if (drn) begin
          ld_fwd = 1'b1;
          st_d   = S_ONE;
        end
      end
      default: begin
        if (acc) begin
          ld_in = 1'b1;
          st_d  = S_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_EMPTY;
      rdy_q  <= 1'b0;
      main_q <= '{pc: '0, instr: NOP_INSTR};
      skid_q <= '{pc: '0, instr: NOP_INSTR};
    end else if (flush) begin
      st_q  <= S_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != S_TWO);
      if (ld_in)   main_q <= in_e;
      if (ld_fwd)  main_q <= skid_q;
      if (ld_skid) skid_q <= in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_elastic.sv
// Directed bench for if_id_pipe_elastic: SKID=1 (CNT_W=4)
// and SKID=0 instances driven from shared inputs.
module tb_if_id_pipe_elastic;

  localparam logic [31:0] N = 32'h00000013;
  localparam logic [31:0] A = 32'h00500093;
  localparam logic [31:0] B = 32'h00600113;
  localparam logic [31:0] C = 32'h002081B3;
  localparam logic [31:0] D = 32'h00100093;
  localparam logic [31:0] E = 32'h00200113;
  localparam logic [31:0] F = 32'h00300193;
  localparam logic [31:0] G = 32'h00400213;
  localparam logic [31:0] H = 32'h00500293;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        rdy1, ov1;
  logic [31:0] pc1, ins1;
  logic [3:0]  st1;

  logic        rdy0, ov0;
  logic [31:0] pc0, ins0;
  logic [15:0] st0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_pipe_elastic #(.SKID(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(ov1), .out_ready(out_ready),
    .out_pc(pc1), .out_instr(ins1),
    .stall_cnt(st1)
  );

  if_id_pipe_elastic #(.SKID(0)) u_s0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(ov0), .out_ready(out_ready),
    .out_pc(pc0), .out_instr(ins0),
    .stall_cnt(st0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_rdy;
    logic [3:0]  e_st;
  } vec_t;

  vec_t v[22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl,
                       input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    v[0]  = '{0, 32'h0,   0, 0, 1, 0, 32'h0,   N, 0, 0};
    v[1]  = '{1, 32'h0,   A, 0, 1, 0, 32'h0,   N, 1, 0};
    v[2]  = '{1, 32'h4,   B, 0, 1, 1, 32'h0,   A, 1, 0};
    v[3]  = '{1, 32'h8,   C, 0, 1, 1, 32'h4,   B, 1, 0};
    v[4]  = '{0, 32'h0,   0, 0, 1, 1, 32'h8,   C, 1, 0};
    v[5]  = '{0, 32'h0,   0, 0, 1, 0, 32'h8,   N, 1, 0};
    v[6]  = '{1, 32'h0,   A, 0, 0, 0, 32'h8,   N, 1, 0};
    v[7]  = '{1, 32'h4,   B, 0, 0, 1, 32'h0,   A, 1, 0};
    v[8]  = '{1, 32'h8,   C, 0, 0, 1, 32'h0,   A, 0, 1};
    v[9]  = '{1, 32'h8,   C, 0, 0, 1, 32'h0,   A, 0, 2};
    v[10] = '{1, 32'h8,   C, 0, 1, 1, 32'h0,   A, 0, 3};
    v[11] = '{1, 32'h8,   C, 0, 1, 1, 32'h4,   B, 1, 3};
    v[12] = '{0, 32'h0,   0, 0, 1, 1, 32'h8,   C, 1, 3};
    v[13] = '{0, 32'h0,   0, 0, 1, 0, 32'h8,   N, 1, 3};
    v[14] = '{1, 32'h10,  D, 0, 0, 0, 32'h8,   N, 1, 3};
    v[15] = '{1, 32'h14,  E, 0, 0, 1, 32'h10,  D, 1, 3};
    v[16] = '{1, 32'h18,  F, 1, 0, 1, 32'h10,  D, 0, 4};
    v[17] = '{1, 32'h100, G, 0, 1, 0, 32'h10,  N, 1, 5};
    v[18] = '{0, 32'h0,   0, 0, 1, 1, 32'h100, G, 1, 5};
    v[19] = '{0, 32'h0,   0, 0, 1, 0, 32'h100, N, 1, 5};
    v[20] = '{1, 32'h200, H, 1, 1, 0, 32'h100, N, 1, 5};
    v[21] = '{0, 32'h0,   0, 0, 1, 0, 32'h100, N, 1, 5};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_ov", {31'd0, ov1}, 0);
    chk("rst_pc", pc1, 0);
    chk("rst_ins", ins1, N);
    chk("rst_stall", {28'd0, st1}, 0);
    chk("rst_rdy", {31'd0, rdy1}, 0);
    chk("rst_rdy_s0", {31'd0, rdy0}, 0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(v[i].iv, v[i].pc, v[i].ins, v[i].fl, v[i].ordy);
      #1;
      chk($sformatf("v%0d_ov", i), {31'd0, ov1}, {31'd0, v[i].e_ov});
      chk($sformatf("v%0d_pc", i), pc1, v[i].e_pc);
      chk($sformatf("v%0d_ins", i), ins1, v[i].e_ins);
      chk($sformatf("v%0d_rdy", i), {31'd0, rdy1},
          {31'd0, v[i].e_rdy});
      chk($sformatf("v%0d_st", i), {28'd0, st1},
          {28'd0, v[i].e_st});
      tick();
    end

    // Saturation of the 4-bit counter vs 16-bit one
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    drive(1, 32'h300, A, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("sat_stall", {28'd0, st1}, 15);
    chk("sat_stall_s0", {16'd0, st0}, 20);
    chk("sat_ov", {31'd0, ov1}, 1);
    chk("sat_pc", pc1, 32'h300);
    chk("sat_ins", ins1, A);
    rst = 1'b1;
    tick();
    chk("sat_clr", {28'd0, st1}, 0);
    chk("sat_clr_ov", {31'd0, ov1}, 0);

    // rst together with flush while holding an entry
    rst = 1'b0;
    tick();
    drive(1, 32'h500, B, 0, 0);
    tick();
    chk("rf_pre_ov", {31'd0, ov1}, 1);
    rst = 1'b1;
    drive(1, 32'h504, C, 1, 0);
    tick();
    chk("rf_ov", {31'd0, ov1}, 0);
    chk("rf_pc", pc1, 0);
    chk("rf_ins", ins1, N);
    chk("rf_stall", {28'd0, st1}, 0);
    chk("rf_rdy", {31'd0, rdy1}, 0);
    chk("rf_rdy_s0", {31'd0, rdy0}, 0);

    // SKID=0: ready follows out_ready in the same cycle
    rst = 1'b0;
    drive(1, 32'h40, D, 0, 0);
    #1;
    chk("s0_rdy_empty", {31'd0, rdy0}, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("s0_ov", {31'd0, ov0}, 1);
    chk("s0_pc", pc0, 32'h40);
    chk("s0_ins", ins0, D);
    chk("s0_rdy_stall", {31'd0, rdy0}, 0);
    out_ready = 1'b1;
    #1;
    chk("s0_rdy_comb", {31'd0, rdy0}, 1);
    drive(1, 32'h44, E, 0, 1);
    tick();
    chk("s0_pass_ov", {31'd0, ov0}, 1);
    chk("s0_pass_pc", pc0, 32'h44);
    chk("s0_pass_ins", ins0, E);
    chk("s0_stall", {16'd0, st0}, 0);
    drive(0, 0, 0, 0, 1);
    tick();
    chk("s0_drain_ov", {31'd0, ov0}, 0);
    chk("s0_drain_ins", ins0, N);
    chk("s0_drain_pc", pc0, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
